// File: rtl/ustore_loader_pkg.sv
// Shared definitions for the writable microcode store and its bench.
package ustore_loader_pkg;

  localparam int unsigned UST_ADDR_W = 4;
  localparam int unsigned UST_DATA_W = 16;
  localparam int unsigned UST_DEPTH  = 1 << UST_ADDR_W;

  // Microword field positions
  localparam int unsigned NXT0_HI = 15;
  localparam int unsigned NXT0_LO = 12;
  localparam int unsigned NXT1_HI = 11;
  localparam int unsigned NXT1_LO = 8;
  localparam int unsigned ZOUT_HI = 7;
  localparam int unsigned ZOUT_LO = 0;

  typedef enum logic [2:0] {
    ST_EMPTY = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // Next address when the sequencer's x input is 0
  function automatic logic [3:0] nxt0(input logic [15:0] w);
    return w[NXT0_HI:NXT0_LO];
  endfunction

  // Next address when the sequencer's x input is 1
  function automatic logic [3:0] nxt1(input logic [15:0] w);
    return w[NXT1_HI:NXT1_LO];
  endfunction

  // Control outputs z7..z0
  function automatic logic [7:0] zout(input logic [15:0] w);
    return w[ZOUT_HI:ZOUT_LO];
  endfunction

endpackage

// File: rtl/ustore_ram.sv
// Microcode storage array: synchronous write, asynchronous read, contents survive reset.
module ustore_ram #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  // Write port
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Zero-latency read for the sequencer
  assign rdata = mem[raddr];

endmodule

// File: rtl/ustore_loader.sv
// Loads a checksummed microcode image over valid/ready and serves it to the sequencer.
module ustore_loader
  import ustore_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = UST_ADDR_W,
  parameter int unsigned DATA_W = UST_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_req,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] a3_a0,
  output logic [DATA_W-1:0] d15_d0,
  output logic              seq_reset_,
  output logic              busy,
  output logic              err
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wcnt, wcnt_nxt;
  logic [DATA_W-1:0] csum, csum_nxt;
  logic [DATA_W-1:0] rd_data;
  logic              err_nxt, wr_ready_nxt, seq_reset_nxt, busy_nxt;
  logic              accept_c, mem_we_c;

  // A word presented together with load_req is dropped by the restart
  assign accept_c = wr_valid & wr_ready & ~load_req;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_nxt;
  end

  // Next state, counter/checksum update and output decode
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    csum_nxt  = csum;
    err_nxt   = err;
    mem_we_c  = 1'b0;
    if (load_req) begin
      state_nxt = ST_LOAD;
      wcnt_nxt  = '0;
      csum_nxt  = '0;
      err_nxt   = 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept_c) begin
            mem_we_c = 1'b1;
            csum_nxt = csum ^ wr_data;
            wcnt_nxt = wcnt + ADDR_W'(1);
            if (wcnt == '1) state_nxt = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (accept_c) begin
            if (wr_data == csum) begin
              state_nxt = ST_RUN;
            end else begin
              state_nxt = ST_ERR;
              err_nxt   = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    wr_ready_nxt  = (state_nxt == ST_LOAD) || (state_nxt == ST_CHECK);
    busy_nxt      = wr_ready_nxt;
    seq_reset_nxt = (state_nxt == ST_RUN);
  end

  // Datapath and registered control outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      wcnt       <= '0;
      csum       <= '0;
      err        <= 1'b0;
      wr_ready   <= 1'b0;
      busy       <= 1'b0;
      seq_reset_ <= 1'b0;
    end else begin
      wcnt       <= wcnt_nxt;
      csum       <= csum_nxt;
      err        <= err_nxt;
      wr_ready   <= wr_ready_nxt;
      busy       <= busy_nxt;
      seq_reset_ <= seq_reset_nxt;
    end
  end

  ustore_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clock (clock),
    .we    (mem_we_c),
    .waddr (wcnt),
    .wdata (wr_data),
    .raddr (a3_a0),
    .rdata (rd_data)
  );

  // Image is only visible once verified
  assign d15_d0 = (state == ST_RUN) ? rd_data : '0;

endmodule

// File: tb/tb_ustore_loader.sv
// Directed + randomized bench for ustore_loader with a behavioural reference model.
module tb_ustore_loader;
  import ustore_loader_pkg::*;

  logic        clock = 1'b0;
  logic        reset, load_req, wr_valid;
  logic [15:0] wr_data;
  logic [3:0]  a3_a0;
  logic        wr_ready, seq_reset_, busy, err;
  logic [15:0] d15_d0;

  int checks = 0;
  int errors = 0;

  ustore_loader dut (
    .clock      (clock),
    .reset      (reset),
    .load_req   (load_req),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .a3_a0      (a3_a0),
    .d15_d0     (d15_d0),
    .seq_reset_ (seq_reset_),
    .busy       (busy),
    .err        (err)
  );

  always #5 clock = ~clock;

  // Reference ROM image from the sequencer's original ROM
  logic [15:0] rom [16];
  // Words fed by feed(): 16 image words then the checksum word
  logic [15:0] img_buf [17];

  // Behavioural model: phase, accepted-word count, running XOR, sticky error, stored words
  localparam int P_EMPTY = 0, P_LOAD = 1, P_RUN = 2, P_ERR = 3;
  int          m_phase;
  int          m_n;
  logic [15:0] m_csum;
  logic        m_err;
  logic [15:0] m_mem [16];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("wr_ready",   16'(wr_ready),   16'(m_phase == P_LOAD));
    chk("busy",       16'(busy),       16'(m_phase == P_LOAD));
    chk("seq_reset_", 16'(seq_reset_), 16'(m_phase == P_RUN));
    chk("err",        16'(err),        16'(m_err));
    chk("d15_d0",     d15_d0,          (m_phase == P_RUN) ? m_mem[a3_a0] : 16'h0);
  endtask

  // Apply the current inputs to the model, clock the DUT, then compare
  task automatic cycle();
    if (reset) begin
      m_phase = P_EMPTY; m_n = 0; m_csum = '0; m_err = 1'b0;
    end else if (load_req) begin
      m_phase = P_LOAD; m_n = 0; m_csum = '0; m_err = 1'b0;
    end else if (m_phase == P_LOAD && wr_valid) begin
      if (m_n < 16) begin
        m_mem[m_n] = wr_data;
        m_csum     = m_csum ^ wr_data;
        m_n++;
      end else begin
        m_n = 0;
        if (wr_data == m_csum) m_phase = P_RUN;
        else begin m_phase = P_ERR; m_err = 1'b1; end
      end
    end
    @(posedge clock);
    #1;
    chk_outputs();
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    wr_valid = 1'b0;
    cycle();
    load_req = 1'b0;
  endtask

  // Feed img_buf[0..count-1]; with gaps, wr_valid drops ~50% of the time
  task automatic feed(input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      bit v;
      int tries = 0;
      do begin
        v = gaps ? bit'($urandom_range(0, 1)) : 1'b1;
        if (tries >= 8) v = 1'b1;
        wr_valid = v;
        wr_data  = v ? img_buf[i] : 16'($urandom);
        cycle();
        tries++;
      end while (!v);
    end
    wr_valid = 1'b0;
  endtask

  task automatic set_rom_image(input logic [15:0] csum);
    for (int i = 0; i < 16; i++) img_buf[i] = rom[i];
    img_buf[16] = csum;
  endtask

  initial begin
    rom = '{16'h120F, 16'h349A, 16'h515B, 16'h759D, 16'h3934, 16'h780C, 16'hAFD3, 16'hB51E,
            16'h9F84, 16'h3DDE, 16'h761A, 16'h598F, 16'h359E, 16'h9F5C, 16'h5C9D, 16'h3DE3};
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_phase = P_EMPTY; m_n = 0; m_csum = '0; m_err = 1'b0;
    reset = 1'b1; load_req = 1'b0; wr_valid = 1'b0; wr_data = '0; a3_a0 = '0;

    // Reset for two clocks
    cycle();
    cycle();
    reset = 1'b0;
    chk("rst_seq_reset_", 16'(seq_reset_), 16'h0);
    chk("rst_d15_d0", d15_d0, 16'h0);

    // Words offered while EMPTY are ignored
    wr_valid = 1'b1; wr_data = 16'hDEAD;
    cycle();
    wr_valid = 1'b0;

    // Clean load of the ROM image
    set_rom_image(16'h1FD5);
    pulse_load();
    feed(17, 1'b0);
    chk("run_seq_reset_", 16'(seq_reset_), 16'h1);
    a3_a0 = 4'd6;  #1; chk("rd_addr6",  d15_d0, 16'hAFD3);
    a3_a0 = 4'd15; #1; chk("rd_addr15", d15_d0, 16'h3DE3);

    // Sequencer walk with x alternating 1,0 against the ROM
    begin
      logic [3:0] addr;
      bit         x;
      addr = 4'd0;
      x    = 1'b1;
      for (int s = 0; s < 24; s++) begin
        a3_a0 = addr;
        #1;
        chk("seq_word", d15_d0, rom[addr]);
        chk("seq_z",    16'(zout(d15_d0)), 16'(zout(rom[addr])));
        addr = x ? nxt1(rom[addr]) : nxt0(rom[addr]);
        x    = ~x;
        cycle();
      end
    end

    // Wrong checksum
    set_rom_image(16'h1FD4);
    pulse_load();
    feed(17, 1'b0);
    chk("bad_err", 16'(err), 16'h1);
    chk("bad_seq_reset_", 16'(seq_reset_), 16'h0);
    chk("bad_d15_d0", d15_d0, 16'h0);
    cycle();
    pulse_load();
    chk("reload_err", 16'(err), 16'h0);
    chk("reload_busy", 16'(busy), 16'h1);

    // Random gaps; RUN only after the 17th accepted word (checked each cycle)
    set_rom_image(16'h1FD5);
    feed(17, 1'b1);
    for (int i = 0; i < 16; i++) begin
      a3_a0 = 4'(i); #1;
      chk("gap_contents", d15_d0, rom[i]);
    end

    // Restart after word 7; the word presented with load_req is discarded
    for (int i = 0; i < 16; i++) img_buf[i] = 16'($urandom);
    pulse_load();
    feed(7, 1'b0);
    load_req = 1'b1; wr_valid = 1'b1; wr_data = 16'hBEEF;
    cycle();
    load_req = 1'b0; wr_valid = 1'b0;
    set_rom_image(16'h1FD5);
    feed(17, 1'b1);
    chk("restart_run", 16'(seq_reset_), 16'h1);
    for (int i = 0; i < 7; i++) begin
      a3_a0 = 4'(i); #1;
      chk("restart_overwrite", d15_d0, rom[i]);
    end

    // Reset at word 10 of a load
    pulse_load();
    feed(10, 1'b0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("midrst_seq_reset_", 16'(seq_reset_), 16'h0);
    chk("midrst_busy", 16'(busy), 16'h0);
    wr_valid = 1'b1; wr_data = 16'h1234;
    cycle();
    cycle();
    wr_valid = 1'b0;

    // Random image with its own checksum, then load_req in RUN
    for (int i = 0; i < 16; i++) img_buf[i] = 16'($urandom);
    img_buf[16] = '0;
    for (int i = 0; i < 16; i++) img_buf[16] = img_buf[16] ^ img_buf[i];
    pulse_load();
    feed(17, 1'b1);
    chk("rand_run", 16'(seq_reset_), 16'h1);
    for (int i = 0; i < 16; i++) begin
      a3_a0 = 4'(i); #1;
      chk("rand_contents", d15_d0, img_buf[i]);
    end
    pulse_load();
    chk("load_in_run_seq_reset_", 16'(seq_reset_), 16'h0);

    // Random image with a corrupted checksum
    img_buf[16] = img_buf[16] ^ 16'(1 << $urandom_range(0, 15));
    feed(17, 1'b1);
    chk("rand_bad_err", 16'(err), 16'h1);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
